// File: rtl/inst_queue.sv
// Circular instruction queue between fetch and decode with flush and occupancy count.
// Optional same-cycle fetch-to-decode bypass when INST_QUEUE_BYPASS_EN is defined.
module inst_queue #(
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       IF_Valid,
  input  logic [31:0]                IF_PC,
  input  logic [31:0]                IF_Instr,
  output logic                       IF_Ready,
  output logic                       ID_Valid,
  input  logic                       ID_Ready,
  output logic [31:0]                ID_PC,
  output logic [31:0]                ID_Instr,
  output logic [15:0]                ID_Imm16,
  input  logic                       Flush,
  output logic [$clog2(DEPTH):0]     Count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL = DEPTH[AW:0];

  // Handshake: a transfer happens on a rising edge where valid && ready are both
  // high; valid never depends on ready on the same side, and Flush withdraws both.

  logic [63:0]   mem [DEPTH];
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr;
  logic [AW:0]   count;
  logic          bypass_hit;
  logic          push;
  logic          pop;
  logic [63:0]   head;

`ifdef INST_QUEUE_BYPASS_EN
  assign bypass_hit = (count == '0) && IF_Valid && !Flush;
`else
  assign bypass_hit = 1'b0;
`endif

  assign IF_Ready = (count < FULL) && !Flush;
  assign ID_Valid = bypass_hit || ((count != '0) && !Flush);

  // A bypassed instruction taken by decode in the same cycle is never stored.
  assign push = IF_Valid && IF_Ready && !(bypass_hit && ID_Ready);
  assign pop  = ID_Valid && ID_Ready && !bypass_hit;

  assign head = mem[rd_ptr];

  always_comb begin
    ID_PC    = '0;
    ID_Instr = '0;
    if (bypass_hit) begin
      ID_PC    = IF_PC;
      ID_Instr = IF_Instr;
    end else if (ID_Valid) begin
      ID_PC    = head[63:32];
      ID_Instr = head[31:0];
    end
  end

  assign ID_Imm16 = ID_Instr[15:0];
  assign Count    = count;

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= {IF_PC, IF_Instr};
    end
  end

  always_ff @(posedge clk) begin
    if (rst || Flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      if (push && !pop) begin
        count <= count + 1'b1;
      end else if (pop && !push) begin
        count <= count - 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_inst_queue.sv
// Randomized and directed bench for inst_queue against a queue-based reference model.
// Honours INST_QUEUE_BYPASS_EN so the model matches whichever build is compiled.
module tb_inst_queue;

  localparam int DEPTH = 4;
`ifdef INST_QUEUE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic        clk;
  logic        rst;
  logic        if_valid_d;
  logic [31:0] if_pc_d;
  logic [31:0] if_instr_d;
  logic        if_ready;
  logic        id_valid;
  logic        id_ready_d;
  logic [31:0] id_pc;
  logic [31:0] id_instr;
  logic [15:0] id_imm16;
  logic        flush_d;
  logic [2:0]  count;

  int checks;
  int failures;

  // Reference model: queued {pc, instr} entries, oldest first.
  logic [63:0] exp_q[$];

  inst_queue #(.DEPTH(DEPTH)) dut (
    .clk      (clk),
    .rst      (rst),
    .IF_Valid (if_valid_d),
    .IF_PC    (if_pc_d),
    .IF_Instr (if_instr_d),
    .IF_Ready (if_ready),
    .ID_Valid (id_valid),
    .ID_Ready (id_ready_d),
    .ID_PC    (id_pc),
    .ID_Instr (id_instr),
    .ID_Imm16 (id_imm16),
    .Flush    (flush_d),
    .Count    (count)
  );

  // Clock/reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  // Driver: apply one cycle of inputs, check outputs mid-cycle, then advance the model.
  task automatic step(input logic iv, input logic [31:0] pc, input logic [31:0] ins,
                      input logic ir, input logic fl, input logic rs);
    logic        e_ifr;
    logic        e_idv;
    logic        byp;
    logic [63:0] e_data;
    int          sz;
    @(negedge clk);
    if_valid_d = iv;
    if_pc_d    = pc;
    if_instr_d = ins;
    id_ready_d = ir;
    flush_d    = fl;
    rst        = rs;
    #2;
    sz     = exp_q.size();
    byp    = BYP && (sz == 0) && iv && !fl;
    e_ifr  = (sz < DEPTH) && !fl;
    e_idv  = byp || ((sz != 0) && !fl);
    e_data = 64'd0;
    if (byp) e_data = {pc, ins};
    else if (e_idv) e_data = exp_q[0];
    check("if_ready", {63'd0, if_ready}, {63'd0, e_ifr});
    check("id_valid", {63'd0, id_valid}, {63'd0, e_idv});
    check("id_pc", {32'd0, id_pc}, {32'd0, e_data[63:32]});
    check("id_instr", {32'd0, id_instr}, {32'd0, e_data[31:0]});
    check("id_imm16", {48'd0, id_imm16}, {48'd0, e_data[15:0]});
    check("count", {61'd0, count}, 64'(sz));
    @(posedge clk);
    if (rs || fl) begin
      exp_q.delete();
    end else if (!(byp && ir)) begin
      if (e_idv && ir) void'(exp_q.pop_front());
      if (iv && e_ifr) exp_q.push_back({pc, ins});
    end
  endtask

  task automatic idle();
    step(1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic fill(input int n, input logic [31:0] base);
    for (int i = 0; i < n; i++) step(1'b1, base + 32'(4 * i), $urandom, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    checks     = 0;
    failures   = 0;
    rst        = 1'b1;
    if_valid_d = 1'b0;
    if_pc_d    = '0;
    if_instr_d = '0;
    id_ready_d = 1'b0;
    flush_d    = 1'b0;
    repeat (2) @(posedge clk);
    step(1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b1);
    idle();

    // Single instruction through an empty queue
    step(1'b1, 32'hBFC00000, 32'h3C08ABCD, 1'b1, 1'b0, 1'b0);
    step(1'b0, 32'd0, 32'd0, 1'b1, 1'b0, 1'b0);
    idle();

    // Overfill with decode stalled, then drain in order
    for (int i = 0; i < 5; i++) step(1'b1, 32'(4 * i), 32'h1000 + 32'(i), 1'b0, 1'b0, 1'b0);
    step(1'b1, 32'h10, 32'h1004, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) step(1'b0, 32'd0, 32'd0, 1'b1, 1'b0, 1'b0);

    // Steady state at two entries with pointer wrap
    fill(2, 32'h2000);
    for (int i = 0; i < 10; i++) step(1'b1, 32'h3000 + 32'(4 * i), $urandom, 1'b1, 1'b0, 1'b0);
    step(1'b1, 32'h0, 32'h0, 1'b1, 1'b1, 1'b0);

    // Flush with push and pop offered at three entries
    fill(3, 32'h4000);
    step(1'b1, 32'h5000, 32'h12345678, 1'b1, 1'b1, 1'b0);
    idle();
    step(1'b1, 32'h5004, 32'h9ABC0001, 1'b0, 1'b0, 1'b0);
    step(1'b0, 32'd0, 32'd0, 1'b1, 1'b0, 1'b0);

    // Reset mid-stream at three entries
    fill(3, 32'h6000);
    step(1'b1, 32'h7000, 32'hDEADBEEF, 1'b0, 1'b0, 1'b1);
    idle();

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      step(1'($urandom_range(0, 3) != 0), $urandom, $urandom,
           1'($urandom_range(0, 2) != 0),
           1'($urandom_range(0, 29) == 0),
           1'($urandom_range(0, 79) == 0));
    end
    for (int i = 0; i < 6; i++) step(1'b0, 32'd0, 32'd0, 1'b1, 1'b0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/inst_queue.md
INST_QUEUE -- requirements
Module: inst_queue

Interface
REQ-001 SHALL provide parameter DEPTH, default 4, number of buffered fetch entries; legal values are powers of two from 2 to 16.
REQ-002 SHALL provide port clk, input, 1 bit, single clock; all state updates occur on the rising edge.
REQ-003 SHALL provide port rst, input, 1 bit, reset; it is synchronous and active-high.
REQ-004 SHALL provide port IF_Valid, input, 1 bit, fetch presents an instruction this cycle.
REQ-005 SHALL provide port IF_PC, input, 32 bits, PC of the presented instruction.
REQ-006 SHALL provide port IF_Instr, input, 32 bits, the presented instruction word.
REQ-007 SHALL provide port IF_Ready, output, 1 bit, the queue accepts the presented instruction this cycle.
REQ-008 SHALL provide port ID_Valid, output, 1 bit, the head entry is valid for decode.
REQ-009 SHALL provide port ID_Ready, input, 1 bit, decode consumes the head this cycle.
REQ-010 SHALL provide port ID_PC, output, 32 bits, PC of the head entry.
REQ-011 SHALL provide port ID_Instr, output, 32 bits, instruction word of the head entry.
REQ-012 SHALL provide port ID_Imm16, output, 16 bits, equal to ID_Instr[15:0] and fed to the immediate extender.
REQ-013 SHALL provide port Flush, input, 1 bit, discard all queued contents (branch redirect or exception).
REQ-014 SHALL provide port Count, output, log2(DEPTH)+1 bits, current occupancy.

Function
REQ-015 SHALL operate as a circular FIFO with read pointer, write pointer, and occupancy counter; both pointers wrap modulo DEPTH.
REQ-016 SHALL perform a push when IF_Valid && IF_Ready, writing {IF_PC, IF_Instr} at the write pointer and advancing it by 1.
REQ-017 SHALL perform a pop when ID_Valid && ID_Ready, advancing the read pointer by 1.
REQ-018 SHALL drive IF_Ready = (Count < DEPTH) && !Flush, combinationally; a full queue SHALL NOT accept a push, even alongside a pop.
REQ-019 SHALL drive ID_Valid = (Count != 0) && !Flush, except where REQ-029 applies.
REQ-020 SHALL drive ID_PC, ID_Instr and ID_Imm16 from the head entry when ID_Valid is 1, and drive them to 0 (a NOP) when ID_Valid is 0.
REQ-021 SHALL update Count by +1 on a push alone, -1 on a pop alone, and leave it unchanged on a simultaneous push and pop.
REQ-022 SHALL preserve ordering: instructions reach decode in exactly their push order, with no loss or duplication.
REQ-023 SHALL give Flush priority over push and pop in its cycle; at the next edge, Count and both pointers are 0 and no push or pop from the flush cycle has taken effect.
REQ-024 SHALL make entries pushed in the cycle after Flush deasserts appear at ID on the following cycle, as normal.
REQ-025 SHALL have a latency of 1 cycle from push to ID_Valid when the queue is empty and REQ-029 does not apply.
REQ-026 SHALL leave Count, pointers and storage unchanged when IF_Valid is held high while full.

Reset
REQ-027 SHALL, when rst is 1 at a clock edge, set Count, read pointer and write pointer to 0; outputs are then IF_Ready=1, ID_Valid=0, ID_PC=0, ID_Instr=0, ID_Imm16=0.
REQ-028 SHALL give rst priority over Flush, push and pop; rst asserted mid-stream discards all entries, and storage contents need not be cleared.

Configuration
REQ-029 SHALL, when macro INST_QUEUE_BYPASS_EN is defined and Count == 0 && IF_Valid && !Flush, drive ID_Valid=1 with ID data taken combinationally from IF_PC and IF_Instr. If ID_Ready is also 1, the instruction is consumed and not stored, and Count stays 0. If ID_Ready is 0, the instruction is pushed normally.
REQ-030 SHALL, without INST_QUEUE_BYPASS_EN, have no combinational path from IF_* to ID_*, and every instruction incurs the 1-cycle latency of REQ-025.

Verification
REQ-031 SHALL cover the following scenario: reset, then IF_Valid=1 with IF_PC=0xBFC00000 and IF_Instr=0x3C08ABCD, ID_Ready=1 -> next cycle ID_Valid=1, ID_Instr=0x3C08ABCD, ID_Imm16=0xABCD, then Count returns to 0 (with bypass: ID_Valid=1 in the same cycle, Count stays 0).
REQ-032 SHALL cover the following scenario: ID_Ready=0 while 5 pushes are offered with DEPTH=4 -> IF_Ready=0 after the 4th push, Count=4, and the 5th push is held; then ID_Ready=1 pops PCs 0x00, 0x04, 0x08, 0x0C in order.
REQ-033 SHALL cover the following scenario: Count=2 with simultaneous push and pop for 10 cycles -> Count stays 2, both pointers wrap past 3, and the output order equals the input order.
REQ-034 SHALL cover the following scenario: Count=3 with Flush=1 together with IF_Valid=1 and ID_Ready=1 -> in that cycle ID_Valid=0 and IF_Ready=0; next cycle Count=0 and ID_Valid=0.
REQ-035 SHALL cover the following scenario: Count=3 with rst=1 asserted together with Flush=0 and IF_Valid=1 -> next cycle Count=0, ID_Valid=0, ID_Instr=0, IF_Ready=1.
